connect_drop_engine: RTL

Parametrised successor to the fixed 16-cell Connect-4 column-select/turn FSM pair. It keeps the two-player board state in a configurable ROWS x COLS grid and accepts one disc drop per request. Each column's fill height is tracked in its own counter. After every placement the block runs a WIN_LEN-in-a-row win check (horizontal, vertical, both diagonals) and a draw check, then updates turn and game status. It sits between the column-input debouncer and the board display driver.

---
 rtl/connect_drop_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/connect_drop_engine.sv
// Two-player drop-disc board engine: accepts one column drop per request, places the disc,
// then checks the mover's WIN_LEN-in-a-row runs and board-full draw before passing the turn.
module connect_drop_engine #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4,
  parameter int COL_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  input  logic                 drop_valid,
  input  logic [COL_W-1:0]     drop_col,
  output logic                 busy,
  output logic                 drop_done,
  output logic                 invalid_column,
  output logic                 player_turn,
  output logic [1:0]           game_status,
  output logic [ROWS*COLS-1:0] board_occ,
  output logic [ROWS*COLS-1:0] board_owner,
  output logic [1:0]           fsm_state
);

  localparam int CELLS = ROWS * COLS;
  localparam int HW    = $clog2(ROWS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLACE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  logic [1:0]       state;
  logic [COL_W-1:0] col_q;
  logic [HW-1:0]    height [COLS];

  // Handshake: drop_valid/drop_col are consumed only while the FSM sits in IDLE (busy=0 and
  // game_status=00); there is no ready and no queue, so a request seen in any other state is lost.
  logic          col_ok;
  logic [HW-1:0] col_height;

  always_comb begin
    col_ok     = 1'b0;
    col_height = '0;
    for (int i = 0; i < COLS; i++) begin
      if (drop_col == COL_W'(i)) begin
        col_ok     = 1'b1;
        col_height = height[i];
      end
    end
  end

  // Cells held by the player who just moved; each cell anchors one run per direction.
  logic [CELLS-1:0] mine;
  logic [CELLS-1:0] run_h, run_v, run_d, run_a;
  logic             win;
  logic             full;

  assign mine = board_occ & (player_turn ? board_owner : ~board_owner);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c + WIN_LEN <= COLS) begin : g_h
        logic [WIN_LEN-1:0] bits;
        for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
          assign bits[k] = mine[r*COLS + c + k];
        end
        assign run_h[r*COLS + c] = &bits;
      end else begin : g_nh
        assign run_h[r*COLS + c] = 1'b0;
      end

      if (r + WIN_LEN <= ROWS) begin : g_v
        logic [WIN_LEN-1:0] bits;
        for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
          assign bits[k] = mine[(r + k)*COLS + c];
        end
        assign run_v[r*COLS + c] = &bits;
      end else begin : g_nv
        assign run_v[r*COLS + c] = 1'b0;
      end

      if ((r + WIN_LEN <= ROWS) && (c + WIN_LEN <= COLS)) begin : g_d
        logic [WIN_LEN-1:0] bits;
        for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
          assign bits[k] = mine[(r + k)*COLS + c + k];
        end
        assign run_d[r*COLS + c] = &bits;
      end else begin : g_nd
        assign run_d[r*COLS + c] = 1'b0;
      end

      if ((r + WIN_LEN <= ROWS) && (c >= WIN_LEN - 1)) begin : g_a
        logic [WIN_LEN-1:0] bits;
        for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
          assign bits[k] = mine[(r + k)*COLS + c - k];
        end
        assign run_a[r*COLS + c] = &bits;
      end else begin : g_na
        assign run_a[r*COLS + c] = 1'b0;
      end
    end
  end

  assign win       = |(run_h | run_v | run_d | run_a);
  assign full      = &board_occ;
  assign busy      = (state == PLACE) || (state == CHECK);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state          <= IDLE;
      col_q          <= '0;
      board_occ      <= '0;
      board_owner    <= '0;
      player_turn    <= 1'b0;
      game_status    <= 2'b00;
      drop_done      <= 1'b0;
      invalid_column <= 1'b0;
      for (int c = 0; c < COLS; c++) height[c] <= '0;
    end else begin
      drop_done      <= 1'b0;
      invalid_column <= 1'b0;
      case (state)
        IDLE: begin
          if (drop_valid) begin
            if (col_ok && (col_height != HW'(ROWS))) begin
              col_q <= drop_col;
              state <= PLACE;
            end else begin
              invalid_column <= 1'b1;
            end
          end
        end
        PLACE: begin
          for (int c = 0; c < COLS; c++) begin
            if (col_q == COL_W'(c)) begin
              for (int r = 0; r < ROWS; r++) begin
                if (height[c] == HW'(r)) begin
                  board_occ[r*COLS + c]   <= 1'b1;
                  board_owner[r*COLS + c] <= player_turn;
                end
              end
              height[c] <= height[c] + HW'(1);
            end
          end
          state <= CHECK;
        end
        CHECK: begin
          drop_done <= 1'b1;
          if (win) begin
            game_status <= player_turn ? 2'b10 : 2'b01;
            state       <= OVER;
          end else if (full) begin
            game_status <= 2'b11;
            state       <= OVER;
          end else begin
            player_turn <= ~player_turn;
            state       <= IDLE;
          end
        end
        OVER:    state <= OVER;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
